inst_mem: RTL and testbench

Instruction memory responder for the pipeline's fetch stage. It answers the fetch stage's combinational instruction-memory request (chip enable plus byte address) with a 32-bit instruction word in the same cycle. It also contains a byte-stream program loader that fills the array after reset while holding the core off through `busy_o`.

---
 rtl/inst_mem.sv | 137 +++++++++++++
 tb/tb_inst_mem.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem.sv
// Instruction memory for the fetch stage: zero-latency read port plus a
// byte-stream program loader that fills the array and holds the core off via busy_o.
module inst_mem #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_ce_i,
    input  logic [31:0]           inst_addr_i,
    output logic [31:0]           inst_o,
    output logic                  misalign_o,
    input  logic                  ld_start_i,
    input  logic [ADDR_WIDTH:0]   ld_len_i,
    input  logic                  ld_valid_i,
    input  logic [7:0]            ld_byte_i,
    output logic                  ld_ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ld_err_o
);

    localparam int unsigned         DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_WIDTH:0] len_q, len_d;
    logic [ADDR_WIDTH:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0] ptr_inc;
    logic [1:0]          cnt_q, cnt_d;
    logic [23:0]         asm_q, asm_d;
    logic                err_q, err_d;
    logic [31:0]         mem_q [DEPTH];

    logic                  len_ok;
    logic                  word_wr;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  rd_in_range;

    assign len_ok  = (ld_len_i != '0) && (ld_len_i <= MAX_LEN);
    assign ptr_inc = ptr_q + ONE;
    // Lane 3 is never stored in asm_q: the fourth byte goes straight into the array.
    assign word_wr = (state_q == S_LOAD) && ld_valid_i && (cnt_q == 2'd3) && !rst;

    assign ld_ready_o = (state_q == S_LOAD);
    assign busy_o     = (state_q == S_LOAD);
    assign done_o     = (state_q == S_DONE);
    assign ld_err_o   = err_q;

    // Loader next-state logic: start validation, byte assembly, word pointer advance.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ld_start_i) begin
                    if (len_ok) begin
                        len_d   = ld_len_i;
                        ptr_d   = '0;
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (ld_valid_i) begin
                    cnt_d = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0: asm_d[7:0]   = ld_byte_i;
                        2'd1: asm_d[15:8]  = ld_byte_i;
                        2'd2: asm_d[23:16] = ld_byte_i;
                        default: begin
                            ptr_d = ptr_inc;
                            if (ptr_inc == len_q) begin
                                state_d = S_DONE;
                            end
                        end
                    endcase
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Loader state registers with synchronous reset; partial word is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            asm_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            err_q   <= err_d;
        end
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem_q[ptr_q[ADDR_WIDTH-1:0]] <= {ld_byte_i, asm_q};
        end
    end

    assign rd_idx      = inst_addr_i[ADDR_WIDTH+1:2];
    assign rd_in_range = (inst_addr_i[31:ADDR_WIDTH+2] == '0);

    // Combinational fetch read; NOP when disabled, loading, or out of range.
    always_comb begin
        inst_o     = NOP_WORD;
        misalign_o = inst_ce_i && (inst_addr_i[1:0] != 2'b00);
        if (inst_ce_i && !busy_o && rd_in_range) begin
            inst_o = mem_q[rd_idx];
        end
    end

endmodule

// File: tb/tb_inst_mem.sv
module tb_inst_mem;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_ce_i;
    logic [31:0]   inst_addr_i;
    logic [31:0]   inst_o;
    logic          misalign_o;
    logic          ld_start_i;
    logic [AW:0]   ld_len_i;
    logic          ld_valid_i;
    logic [7:0]    ld_byte_i;
    logic          ld_ready_o;
    logic          busy_o;
    logic          done_o;
    logic          ld_err_o;

    always #5 clk = ~clk;

    inst_mem #(.ADDR_WIDTH(AW), .NOP_WORD(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_ce_i   (inst_ce_i),
        .inst_addr_i (inst_addr_i),
        .inst_o      (inst_o),
        .misalign_o  (misalign_o),
        .ld_start_i  (ld_start_i),
        .ld_len_i    (ld_len_i),
        .ld_valid_i  (ld_valid_i),
        .ld_byte_i   (ld_byte_i),
        .ld_ready_o  (ld_ready_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ld_err_o    (ld_err_o)
    );

    // Reference model: what the array should hold, and the words of the current load.
    logic [31:0] ref_mem  [DEPTH];
    logic [31:0] load_buf [DEPTH];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_inst(input logic ce, input logic [31:0] addr, input bit loading);
        if (!ce || loading || addr >= 4 * DEPTH) return NOP;
        return ref_mem[addr / 4];
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        sel = $urandom_range(0, 9);
        if (sel < 6) return 4 * $urandom_range(0, DEPTH - 1);
        if (sel == 6) return 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
        if (sel == 7) return 4 * DEPTH + 4 * $urandom_range(0, 255);
        if (sel == 8) return $urandom | 32'h8000_0000;
        return ($urandom_range(0, 1) == 0) ? 4 * DEPTH : 4 * (DEPTH - 1);
    endfunction

    task automatic check_read(input string tag, input bit loading);
        logic [31:0] a;
        a = inst_addr_i;
        check({tag, "_inst"}, inst_o, model_inst(inst_ce_i, a, loading));
        check({tag, "_misalign"}, {31'd0, misalign_o}, {31'd0, inst_ce_i && (a % 4 != 0)});
    endtask

    // mode 0: valid always high, 1: valid toggles, 2: random gaps + ignored start pulses.
    // abort_after > 0 resets the block once that many bytes have been accepted.
    task automatic do_load(input int unsigned len, input int unsigned mode, input int unsigned abort_after);
        int unsigned nbytes;
        int unsigned sent;
        bit          v;
        bit          vphase;
        logic [31:0] w;
        nbytes = len * 4;
        sent   = 0;
        vphase = 1'b0;
        ld_start_i = 1'b1;
        ld_len_i   = len[AW:0];
        @(posedge clk); #1;
        ld_start_i = 1'b0;
        while (sent < nbytes) begin
            case (mode)
                0: v = 1'b1;
                1: begin vphase = ~vphase; v = vphase; end
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            w = load_buf[sent / 4];
            ld_valid_i = v;
            ld_byte_i  = v ? w[8 * (sent % 4) +: 8] : 8'($urandom);
            if (mode == 2 && $urandom_range(0, 15) == 0) begin
                ld_start_i = 1'b1;
                ld_len_i   = (AW + 1)'($urandom);
            end
            inst_ce_i   = ($urandom_range(0, 3) != 0);
            inst_addr_i = 4 * $urandom_range(0, DEPTH - 1);
            @(negedge clk);
            check("ld_ready", {31'd0, ld_ready_o}, 32'd1);
            check("ld_busy", {31'd0, busy_o}, 32'd1);
            check("ld_done", {31'd0, done_o}, 32'd0);
            check_read("ld_fetch", 1'b1);
            @(posedge clk); #1;
            ld_start_i = 1'b0;
            if (v) begin
                sent++;
                if (sent % 4 == 0) ref_mem[sent / 4 - 1] = load_buf[sent / 4 - 1];
            end
            if (abort_after != 0 && sent == abort_after) begin
                ld_valid_i = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check("abort_busy", {31'd0, busy_o}, 32'd0);
                check("abort_ready", {31'd0, ld_ready_o}, 32'd0);
                check("abort_done", {31'd0, done_o}, 32'd0);
                @(posedge clk); #1;
                @(negedge clk);
                check("abort_done2", {31'd0, done_o}, 32'd0);
                return;
            end
        end
        ld_valid_i = 1'b0;
        @(negedge clk);
        check("done_pulse", {31'd0, done_o}, 32'd1);
        check("done_busy", {31'd0, busy_o}, 32'd0);
        check("done_ready", {31'd0, ld_ready_o}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_done", {31'd0, done_o}, 32'd0);
        check("post_ready", {31'd0, ld_ready_o}, 32'd0);
    endtask

    task automatic err_start(input logic [AW:0] len);
        @(posedge clk); #1;
        ld_start_i = 1'b1;
        ld_len_i   = len;
        @(negedge clk);
        check("err_early", {31'd0, ld_err_o}, 32'd0);
        @(posedge clk); #1;
        ld_start_i = 1'b0;
        @(negedge clk);
        check("err_pulse", {31'd0, ld_err_o}, 32'd1);
        check("err_ready", {31'd0, ld_ready_o}, 32'd0);
        check("err_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("err_clear", {31'd0, ld_err_o}, 32'd0);
        check("err_idle", {31'd0, ld_ready_o}, 32'd0);
    endtask

    task automatic random_reads(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk); #1;
            inst_ce_i   = ($urandom_range(0, 3) != 0);
            inst_addr_i = rand_addr();
            @(negedge clk);
            check_read("rd", 1'b0);
        end
    endtask

    task automatic read_at(input string tag, input logic ce, input logic [31:0] addr);
        @(posedge clk); #1;
        inst_ce_i   = ce;
        inst_addr_i = addr;
        @(negedge clk);
        check_read(tag, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        inst_ce_i = 1'b0;
        inst_addr_i = '0;
        ld_start_i = 1'b0;
        ld_len_i = '0;
        ld_valid_i = 1'b0;
        ld_byte_i = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_ready", {31'd0, ld_ready_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_err", {31'd0, ld_err_o}, 32'd0);
        check("rst_ce0", inst_o, 32'h0000_0013);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fill the whole array (maximum legal length) with random gaps.
        for (int unsigned i = 0; i < DEPTH; i++) load_buf[i] = $urandom;
        do_load(DEPTH, 2, 0);
        read_at("top_word", 1'b1, 4 * (DEPTH - 1));
        read_at("word0", 1'b1, 32'h0);
        random_reads(80);

        // Two-word program with valid held high.
        load_buf[0] = 32'h0050_0513;
        load_buf[1] = 32'h0010_0593;
        do_load(2, 0, 0);
        inst_ce_i = 1'b1;
        inst_addr_i = 32'h4;
        #1;
        check("two_w1", inst_o, 32'h0010_0593);
        inst_addr_i = 32'h0;
        #1;
        check("two_w0", inst_o, 32'h0050_0513);

        // Same load with valid toggling each cycle.
        do_load(2, 1, 0);
        read_at("stall_w0", 1'b1, 32'h0);
        read_at("stall_w1", 1'b1, 32'h4);

        err_start('0);
        err_start((AW + 1)'(DEPTH + 1));
        read_at("after_err", 1'b1, 32'h4);

        // Reset after 5 bytes: first word committed, second untouched.
        load_buf[0] = 32'hA1B2_C3D4;
        load_buf[1] = 32'h1122_3344;
        do_load(2, 0, 5);
        read_at("abort_w0", 1'b1, 32'h0);
        read_at("abort_w1", 1'b1, 32'h4);
        inst_addr_i = 32'h4;
        #1;
        check("abort_w1_kept", inst_o, 32'h0010_0593);

        // Fresh load after the aborted one.
        load_buf[0] = $urandom;
        load_buf[1] = $urandom;
        load_buf[2] = $urandom;
        do_load(3, 2, 0);
        read_at("fresh_w0", 1'b1, 32'h0);
        read_at("fresh_w2", 1'b1, 32'h8);

        // Read edge cases.
        read_at("mis2", 1'b1, 32'h0000_0002);
        read_at("oor", 1'b1, 4 * DEPTH);
        read_at("ce0", 1'b0, 32'h8);
        random_reads(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
